// File: rtl/ysyx_l1i_cache_pkg.sv
// ysyx_l1i_cache_pkg
//   Shared definitions for the L1 instruction cache: the refill FSM state
//   encoding, default geometry, and helpers that derive the address-split
//   bit positions (byte offset / word offset / index / tag) from the
//   geometry parameters.
package ysyx_l1i_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } l1i_state_e;

  localparam int L1I_BYTE_OFF_W   = 2;
  localparam int L1I_DEF_DATA_W   = 32;
  localparam int L1I_DEF_SET_LEN  = 2;
  localparam int L1I_DEF_LINE_LEN = 1;
  localparam int L1I_DEF_BURST    = 1;

  // lowest pc bit of the set index
  function automatic int l1i_idx_lsb(input int line_len);
    return line_len + L1I_BYTE_OFF_W;
  endfunction

  // lowest pc bit of the tag
  function automatic int l1i_tag_lsb(input int set_len, input int line_len);
    return set_len + line_len + L1I_BYTE_OFF_W;
  endfunction

  function automatic int l1i_tag_w(input int data_w, input int set_len, input int line_len);
    return data_w - l1i_tag_lsb(set_len, line_len);
  endfunction

endpackage

// File: rtl/ysyx_l1i_bank.sv
// ysyx_l1i_bank
//   Direct-mapped data + tag storage for the L1 instruction cache.
//   One synchronous write port for refill words, one synchronous write port
//   for tags, and a combinational read port addressed by the fetch pc.
//   Contents are deliberately not reset; validity is tracked by the cache.
// Ports
//   clk                                  clock
//   data_we / data_set / data_word /
//   data_wdata                           refill word write
//   tag_we / tag_set / tag_wdata         tag write
//   rd_set / rd_word                     read address
//   rd_data / rd_tag                     read data (combinational)
import ysyx_l1i_cache_pkg::*;

module ysyx_l1i_bank #(
  parameter int DATA_W   = L1I_DEF_DATA_W,
  parameter int SET_LEN  = L1I_DEF_SET_LEN,
  parameter int LINE_LEN = L1I_DEF_LINE_LEN,
  parameter int TAG_W    = l1i_tag_w(L1I_DEF_DATA_W, L1I_DEF_SET_LEN, L1I_DEF_LINE_LEN)
) (
  input  logic                clk,
  input  logic                data_we,
  input  logic [SET_LEN-1:0]  data_set,
  input  logic [LINE_LEN-1:0] data_word,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic                tag_we,
  input  logic [SET_LEN-1:0]  tag_set,
  input  logic [TAG_W-1:0]    tag_wdata,
  input  logic [SET_LEN-1:0]  rd_set,
  input  logic [LINE_LEN-1:0] rd_word,
  output logic [DATA_W-1:0]   rd_data,
  output logic [TAG_W-1:0]    rd_tag
);

  localparam int LINES = 1 << SET_LEN;
  localparam int WORDS = 1 << LINE_LEN;

  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_set][data_word] <= data_wdata;
    if (tag_we)  tag_mem[tag_set] <= tag_wdata;
  end

  assign rd_data = data_mem[rd_set][rd_word];
  assign rd_tag  = tag_mem[rd_set];

endmodule

// File: rtl/ysyx_l1i_cache.sv
// ysyx_l1i_cache
//   Direct-mapped L1 instruction cache with zero-cycle hit latency and a
//   simple AR/R refill port. A miss refills the whole line starting at
//   word 0, either as one burst (BURST=1) or one single-beat request per
//   word with a one-cycle idle gap between requests (BURST=0).
//   flush_i invalidates every line; during a refill it is remembered and
//   applied when the refill finishes, so the refilled line is discarded.
// Ports
//   clk, rst (async, active-low)
//   pc_i, req_i, flush_i                 fetch side inputs
//   inst_o, hit_o, busy_o                fetch side outputs
//   bus_araddr_o, bus_arvalid_o,
//   bus_arlen_o, bus_required_o          read request channel
//   bus_rdata_i, bus_rvalid_i,
//   bus_rlast_i                          read data channel
//
// state  | meaning
// S_IDLE | serving hits; a miss starts a refill, flush clears all lines
// S_FILL | read request outstanding / collecting refill beats
// S_GAP  | one idle cycle between single-word requests (BURST=0)
// S_DONE | refill complete; tag written, line validated unless flushed
import ysyx_l1i_cache_pkg::*;

module ysyx_l1i_cache #(
  parameter int DATA_W   = L1I_DEF_DATA_W,
  parameter int SET_LEN  = L1I_DEF_SET_LEN,
  parameter int LINE_LEN = L1I_DEF_LINE_LEN,
  parameter int BURST    = L1I_DEF_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              req_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              hit_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] bus_araddr_o,
  output logic              bus_arvalid_o,
  output logic [7:0]        bus_arlen_o,
  output logic              bus_required_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_rvalid_i,
  input  logic              bus_rlast_i
);

  localparam int LINES   = 1 << SET_LEN;
  localparam int WORDS   = 1 << LINE_LEN;
  localparam int IDX_LSB = l1i_idx_lsb(LINE_LEN);
  localparam int TAG_LSB = l1i_tag_lsb(SET_LEN, LINE_LEN);
  localparam int TAG_W   = l1i_tag_w(DATA_W, SET_LEN, LINE_LEN);
  localparam bit BURST_EN = (BURST != 0);
  localparam logic [LINE_LEN:0] LAST_BEAT = (LINE_LEN+1)'(WORDS - 1);
  localparam logic [7:0] ARLEN = BURST_EN ? 8'(WORDS - 1) : 8'd0;

  l1i_state_e          state;
  logic [LINES-1:0]    valid;
  logic [LINE_LEN:0]   beat;
  logic [DATA_W-1:0]   base_addr;
  logic [DATA_W-1:0]   araddr_q;
  logic                ar_pend;
  logic                flush_pend;

  logic [LINE_LEN-1:0] pc_off;
  logic [SET_LEN-1:0]  pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [DATA_W-1:0]   pc_base;
  logic [SET_LEN-1:0]  fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic [DATA_W-1:0]   beat_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [TAG_W-1:0]    rd_tag;
  logic                hit;
  logic                beat_last;
  logic                fill_end;
  logic                unused_pc_lo;

  assign pc_off  = pc_i[IDX_LSB-1:L1I_BYTE_OFF_W];
  assign pc_idx  = pc_i[TAG_LSB-1:IDX_LSB];
  assign pc_tag  = pc_i[DATA_W-1:TAG_LSB];
  assign pc_base = {pc_i[DATA_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
  assign unused_pc_lo = &{1'b0, pc_i[L1I_BYTE_OFF_W-1:0]};

  // base_addr always holds the line being refilled
  assign fill_idx  = base_addr[TAG_LSB-1:IDX_LSB];
  assign fill_tag  = base_addr[DATA_W-1:TAG_LSB];
  assign beat_addr = base_addr + (DATA_W'(beat) << L1I_BYTE_OFF_W);

  // an early rlast only ends a burst; single-word requests always carry rlast
  assign beat_last = (beat == LAST_BEAT);
  assign fill_end  = beat_last || (BURST_EN && bus_rlast_i);

  // DONE keeps serving hits for other lines; the refilled line's own valid
  // bit is still clear in DONE, so it cannot hit before its tag is written
  assign hit = ((state == S_IDLE) || (state == S_DONE)) &&
               valid[pc_idx] && (rd_tag == pc_tag);

  ysyx_l1i_bank #(
    .DATA_W  (DATA_W),
    .SET_LEN (SET_LEN),
    .LINE_LEN(LINE_LEN),
    .TAG_W   (TAG_W)
  ) u_bank (
    .clk       (clk),
    .data_we   ((state == S_FILL) && bus_rvalid_i),
    .data_set  (fill_idx),
    .data_word (beat[LINE_LEN-1:0]),
    .data_wdata(bus_rdata_i),
    .tag_we    (state == S_DONE),
    .tag_set   (fill_idx),
    .tag_wdata (fill_tag),
    .rd_set    (pc_idx),
    .rd_word   (pc_off),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      valid      <= '0;
      beat       <= '0;
      base_addr  <= '0;
      araddr_q   <= '0;
      ar_pend    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_i) begin
            valid <= '0;
          end else if (req_i && !hit) begin
            state          <= S_FILL;
            base_addr      <= pc_base;
            araddr_q       <= pc_base;
            valid[pc_idx]  <= 1'b0;
            beat           <= '0;
            ar_pend        <= 1'b1;
          end
        end
        S_FILL: begin
          if (flush_i) flush_pend <= 1'b1;
          if (bus_rvalid_i) begin
            ar_pend <= 1'b0;
            if (BURST_EN) begin
              if (fill_end) state <= S_DONE;
              else          beat  <= beat + (LINE_LEN+1)'(1);
            end else if (beat_last) begin
              state <= S_DONE;
            end else begin
              beat  <= beat + (LINE_LEN+1)'(1);
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (flush_i) flush_pend <= 1'b1;
          state    <= S_FILL;
          ar_pend  <= 1'b1;
          araddr_q <= beat_addr;
        end
        S_DONE: begin
          if (flush_pend || flush_i) valid <= '0;
          else                       valid[fill_idx] <= 1'b1;
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign inst_o         = rd_data;
  assign hit_o          = hit;
  assign busy_o         = (state != S_IDLE) || flush_pend;
  assign bus_araddr_o   = araddr_q;
  assign bus_arvalid_o  = ar_pend;
  assign bus_arlen_o    = ARLEN;
  assign bus_required_o = (state != S_IDLE);

endmodule
